// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address type for the multi-port register file.
package regfile_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register busy scoreboard; an issue-time set beats a same-edge write clear.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_R0  = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                clr0_en_i,
    input  logic [AW-1:0]       clr0_addr_i,
    input  logic                clr1_en_i,
    input  logic [AW-1:0]       clr1_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr0_en_i) busy_d[clr0_addr_i] = 1'b0;
        if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
        if (set_en_i && !((ZERO_R0 != 0) && set_addr_i == '0)) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;

    assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports and two prioritised write ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     wr_conflict
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              conflict_q, conflict_d;
    logic              wr0_we, wr1_we;

    // Committed writes: R0 is read-only when zeroed, and wr1 loses to wr0 on a shared address.
    assign wr0_we     = wr0_en && !((ZERO_R0 != 0) && wr0_addr == '0);
    assign wr1_we     = wr1_en && !((ZERO_R0 != 0) && wr1_addr == '0)
                        && !(wr0_en && wr0_addr == wr1_addr);
    assign conflict_d = wr0_we && wr1_en && wr1_addr == wr0_addr;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (wr1_we) regs_q[wr1_addr] <= wr1_data;
            if (wr0_we) regs_q[wr0_addr] <= wr0_data;
            conflict_q <= conflict_d;
        end

    assign wr_conflict = conflict_q;

    regfile_sb #(.NUM_REGS(NUM_REGS), .ZERO_R0(ZERO_R0)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (sb_set_en),
        .set_addr_i  (sb_set_addr),
        .clr0_en_i   (wr0_we),
        .clr0_addr_i (wr0_addr),
        .clr1_en_i   (wr1_we),
        .clr1_addr_i (wr1_addr),
        .busy_o      (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
        logic              b, z;
        assign a = rd_addr[i*AW +: AW];
        assign z = (ZERO_R0 != 0) && a == '0;
`ifdef REGFILE_BYPASS_EN
        logic h0, h1;
        assign h0 = wr0_we && wr0_addr == a;
        assign h1 = wr1_we && wr1_addr == a;
        assign d  = h0 ? wr0_data : h1 ? wr1_data : regs_q[a];
        assign b  = (h0 || h1) ? (sb_set_en && sb_set_addr == a) : busy_vec[a];
`else
        assign d = regs_q[a];
        assign b = busy_vec[a];
`endif
        assign rd_data[i*DATA_W +: DATA_W] = z ? '0 : d;
        assign rd_busy[i]                  = !z && b;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus hand sequences for conflict, scoreboard, R0 and async reset.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en = 1'b0, wr1_en = 1'b0, sb_set_en = 1'b0;
    reg_addr_t   wr0_addr = '0, wr1_addr = '0, sb_set_addr = '0;
    logic [15:0] wr0_data = '0, wr1_data = '0;
    logic [7:0]  busy_vec;
    logic        wr_conflict;
    int          checks = 0, failures = 0;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(busy_vec), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w0e; reg_addr_t w0a; logic [15:0] w0d;
        logic        w1e; reg_addr_t w1a; logic [15:0] w1d;
        logic        se;  reg_addr_t sa;
        reg_addr_t   ra0, ra1;
        logic [15:0] e0, e1;
        logic [1:0]  erb;
        logic [7:0]  ebv;
        logic        ec;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0;
    endtask

    initial begin
        vec[0] = '{1, 3'd3, 16'h1234, 0, 3'd0, 16'h0,    0, 3'd0, 3'd3, 3'd5, 16'h1234, 16'h0000, 2'b00, 8'h00, 0};
        vec[1] = '{1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd5, 3'd3, 16'hAAAA, 16'h1234, 2'b00, 8'h00, 1};
        vec[2] = '{0, 3'd0, 16'h0,    0, 3'd0, 16'h0,    0, 3'd0, 3'd5, 3'd5, 16'hAAAA, 16'hAAAA, 2'b00, 8'h00, 0};
        vec[3] = '{0, 3'd0, 16'h0,    1, 3'd6, 16'hBEEF, 1, 3'd2, 3'd6, 3'd2, 16'hBEEF, 16'h0000, 2'b10, 8'h04, 0};
        vec[4] = '{0, 3'd0, 16'h0,    0, 3'd0, 16'h0,    0, 3'd0, 3'd2, 3'd6, 16'h0000, 16'hBEEF, 2'b01, 8'h04, 0};
        vec[5] = '{0, 3'd0, 16'h0,    1, 3'd2, 16'h2222, 0, 3'd0, 3'd2, 3'd2, 16'h2222, 16'h2222, 2'b00, 8'h00, 0};
        vec[6] = '{1, 3'd2, 16'h3333, 0, 3'd0, 16'h0,    1, 3'd2, 3'd2, 3'd2, 16'h3333, 16'h3333, 2'b11, 8'h04, 0};
        vec[7] = '{1, 3'd0, 16'hFFFF, 1, 3'd0, 16'h1111, 1, 3'd0, 3'd0, 3'd2, 16'h0000, 16'h3333, 2'b10, 8'h04, 0};
        vec[8] = '{1, 3'd1, 16'h0001, 1, 3'd7, 16'h7777, 0, 3'd0, 3'd1, 3'd7, 16'h0001, 16'h7777, 2'b00, 8'h04, 0};
        vec[9] = '{1, 3'd2, 16'h4444, 0, 3'd0, 16'h0,    0, 3'd0, 3'd2, 3'd0, 16'h4444, 16'h0000, 2'b00, 8'h00, 0};

        repeat (2) @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd_addr = {a[2:0], a[2:0]};
            #1;
            check($sformatf("reset_rd_data_r%0d", a), rd_data, 32'h0);
            check($sformatf("reset_rd_busy_r%0d", a), {30'b0, rd_busy}, 32'h0);
        end
        check("reset_busy_vec", {24'b0, busy_vec}, 32'h0);
        check("reset_wr_conflict", {31'b0, wr_conflict}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr0_en = vec[i].w0e; wr0_addr = vec[i].w0a; wr0_data = vec[i].w0d;
            wr1_en = vec[i].w1e; wr1_addr = vec[i].w1a; wr1_data = vec[i].w1d;
            sb_set_en = vec[i].se; sb_set_addr = vec[i].sa;
            @(posedge clk);
            #1;
            idle_inputs();
            rd_addr = {vec[i].ra1, vec[i].ra0};
            #1;
            check($sformatf("v%0d_rd_data0", i), {16'b0, rd_data[15:0]}, {16'b0, vec[i].e0});
            check($sformatf("v%0d_rd_data1", i), {16'b0, rd_data[31:16]}, {16'b0, vec[i].e1});
            check($sformatf("v%0d_rd_busy", i), {30'b0, rd_busy}, {30'b0, vec[i].erb});
            check($sformatf("v%0d_busy_vec", i), {24'b0, busy_vec}, {24'b0, vec[i].ebv});
            check($sformatf("v%0d_wr_conflict", i), {31'b0, wr_conflict}, {31'b0, vec[i].ec});
        end

        // Same-cycle read of a register being written
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'h5A5A;
        rd_addr = {3'd0, 3'd3};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", {16'b0, rd_data[15:0]}, 32'h5A5A);
`else
        check("no_bypass_same_cycle", {16'b0, rd_data[15:0]}, 32'h1234);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("write_next_cycle", {16'b0, rd_data[15:0]}, 32'h5A5A);

        // Asynchronous reset in the middle of a cycle, with a write pending
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h0F0F;
        sb_set_en = 1'b1; sb_set_addr = 3'd4;
        @(posedge clk);
        #1;
        wr0_addr = 3'd6; wr0_data = 16'hCAFE; sb_set_en = 1'b0;
        rd_addr = {3'd6, 3'd1};
        #1;
        check("pre_reset_r1", {16'b0, rd_data[15:0]}, 32'h0F0F);
        check("pre_reset_busy", {24'b0, busy_vec}, 32'h10);
        reset = 1'b1;
        #1;
        check("async_reset_r1", {16'b0, rd_data[15:0]}, 32'h0);
        check("async_reset_busy", {24'b0, busy_vec}, 32'h0);
        @(posedge clk);
        #1;
        check("reset_blocks_write_r6", {16'b0, rd_data[31:16]}, 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("post_reset_conflict", {31'b0, wr_conflict}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
